// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
// Data wins contention up to MaxDataBurst grants; stuck accesses time out.
module mem_port_arbiter #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned MaxDataBurst  = 4,
  parameter int unsigned TimeoutCycles = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_req,
  input  logic [AddrWidth-1:0] if_addr,
  output logic [DataWidth-1:0] if_rdata,
  output logic                 if_done,
  input  logic                 dm_req,
  input  logic                 dm_we,
  input  logic [1:0]           dm_size,
  input  logic [AddrWidth-1:0] dm_addr,
  input  logic [DataWidth-1:0] dm_wdata,
  output logic [DataWidth-1:0] dm_rdata,
  output logic                 dm_done,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [1:0]           mem_size,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [DataWidth-1:0] mem_wdata,
  input  logic [DataWidth-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic                 stall,
  output logic                 timeout_err
);
  localparam int unsigned BurstW = $clog2(MaxDataBurst + 1);
  localparam int unsigned TimerW = $clog2(TimeoutCycles + 1);
  localparam logic [1:0]  SizeWord = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic [BurstW-1:0]    burst_cnt, burst_nxt;
  logic [TimerW-1:0]    timer, timer_nxt;
  logic                 mem_req_nxt, mem_we_nxt, if_done_nxt, dm_done_nxt, timeout_nxt;
  logic [1:0]           mem_size_nxt;
  logic [AddrWidth-1:0] mem_addr_nxt;
  logic [DataWidth-1:0] mem_wdata_nxt, if_rdata_nxt, dm_rdata_nxt;
  logic                 burst_full, grant_d, grant_i, busy, expired;

  // Arbitration: fetch only overrides a data request once the burst limit is hit.
  assign burst_full = (burst_cnt == BurstW'(MaxDataBurst));
  assign grant_d    = (state == IDLE) && dm_req && !(if_req && burst_full);
  assign grant_i    = (state == IDLE) && if_req && !grant_d;
  assign busy       = (state == BUSY_I) || (state == BUSY_D);
  assign expired    = busy && !mem_ack && (timer == TimerW'(TimeoutCycles - 1));

  assign stall = (if_req & ~if_done) | (dm_req & ~dm_done);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d)      state_nxt = BUSY_D;
        else if (grant_i) state_nxt = BUSY_I;
      end
      BUSY_I:  if (mem_ack || expired) state_nxt = DONE_I;
      BUSY_D:  if (mem_ack || expired) state_nxt = DONE_D;
      DONE_I:  state_nxt = IDLE;
      DONE_D:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of every registered output and counter.
  always_comb begin
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_size_nxt  = mem_size;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    if_rdata_nxt  = if_rdata;
    dm_rdata_nxt  = dm_rdata;
    if_done_nxt   = 1'b0;
    dm_done_nxt   = 1'b0;
    timeout_nxt   = timeout_err;
    burst_nxt     = burst_cnt;
    timer_nxt     = timer;
    if (grant_d) begin
      mem_req_nxt   = 1'b1;
      mem_we_nxt    = dm_we;
      mem_size_nxt  = dm_size;
      mem_addr_nxt  = dm_addr;
      mem_wdata_nxt = dm_wdata;
      timer_nxt     = '0;
      burst_nxt     = if_req ? (burst_full ? burst_cnt : burst_cnt + BurstW'(1)) : '0;
    end else if (grant_i) begin
      mem_req_nxt  = 1'b1;
      mem_we_nxt   = 1'b0;
      mem_size_nxt = SizeWord;
      mem_addr_nxt = if_addr;
      timer_nxt    = '0;
      burst_nxt    = '0;
    end else if (busy) begin
      if (mem_ack) begin
        mem_req_nxt = 1'b0;
        if (state == BUSY_I) begin
          if_rdata_nxt = mem_rdata;
          if_done_nxt  = 1'b1;
        end else begin
          dm_rdata_nxt = mem_rdata;
          dm_done_nxt  = 1'b1;
        end
      end else if (expired) begin
        mem_req_nxt = 1'b0;
        timeout_nxt = 1'b1;
        if (state == BUSY_I) begin
          if_rdata_nxt = '0;
          if_done_nxt  = 1'b1;
        end else begin
          dm_rdata_nxt = '0;
          dm_done_nxt  = 1'b1;
        end
      end else begin
        timer_nxt = timer + TimerW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_size    <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_rdata    <= '0;
      dm_rdata    <= '0;
      if_done     <= 1'b0;
      dm_done     <= 1'b0;
      timeout_err <= 1'b0;
      burst_cnt   <= '0;
      timer       <= '0;
    end else begin
      mem_req     <= mem_req_nxt;
      mem_we      <= mem_we_nxt;
      mem_size    <= mem_size_nxt;
      mem_addr    <= mem_addr_nxt;
      mem_wdata   <= mem_wdata_nxt;
      if_rdata    <= if_rdata_nxt;
      dm_rdata    <= dm_rdata_nxt;
      if_done     <= if_done_nxt;
      dm_done     <= dm_done_nxt;
      timeout_err <= timeout_nxt;
      burst_cnt   <= burst_nxt;
      timer       <= timer_nxt;
    end
  end

endmodule
